// File: rtl/descrambler.sv
// Per-lane PCIe RX descrambler: removes Gen1/2 (8b/10b) and Gen3+ (128b/130b)
// scrambling from up to four bytes per clock, with one registered stage.
module descrambler (
    input  logic        clk,
    input  logic        reset,
    input  logic        turnOff,
    input  logic        PIPEDataValid,
    input  logic [5:0]  PIPEWIDTH,
    input  logic [1:0]  PIPESyncHeader,
    input  logic [23:0] seedValue,
    input  logic [31:0] PIPEData,
    input  logic [3:0]  PIPEDataK,
    output logic        descramblerDataValid,
    output logic [31:0] descramblerData,
    output logic [3:0]  descramblerDataK,
    output logic [1:0]  descramblerSyncHeader
);

    localparam logic [15:0] Gen12Seed       = 16'hFFFF;
    localparam logic [15:0] Gen12Mask       = 16'h0039;
    localparam logic [22:0] Gen3Mask        = 23'h210125;
    localparam logic [22:0] Gen3DefaultSeed = 23'h1DBFBC;
    localparam logic [7:0]  ComSymbol       = 8'hBC;
    localparam logic [7:0]  SkpSymbol       = 8'h1C;

    typedef enum logic [1:0] {
        Mode8b10b,
        ModeDataBlock,
        ModeOrderedSet
    } modeT;

    typedef struct packed {
        logic [15:0] state;
        logic [7:0]  key;
    } gen12StepT;

    typedef struct packed {
        logic [22:0] state;
        logic [7:0]  key;
    } gen3StepT;

    // Eight Galois shifts; key bit i is the bit shifted out on the i-th shift.
    function automatic gen12StepT gen12Advance(input logic [15:0] s);
        gen12StepT r;
        logic      o;
        r.state = s;
        r.key   = '0;
        for (int i = 0; i < 8; i++) begin
            o        = r.state[15];
            r.key[i] = o;
            r.state  = {r.state[14:0], 1'b0} ^ (o ? Gen12Mask : 16'h0000);
        end
        return r;
    endfunction

    function automatic gen3StepT gen3Advance(input logic [22:0] s);
        gen3StepT r;
        logic     o;
        r.state = s;
        r.key   = '0;
        for (int i = 0; i < 8; i++) begin
            o        = r.state[22];
            r.key[i] = o;
            r.state  = {r.state[21:0], 1'b0} ^ (o ? Gen3Mask : 23'h000000);
        end
        return r;
    endfunction

    logic [15:0] gen12Q;
    logic [15:0] gen12D;
    logic [22:0] gen3Q;
    logic [22:0] gen3D;
    logic [22:0] gen3Cur;
    logic        gen3Unseeded;
    logic [22:0] effSeed;
    logic [3:0]  activeMask;
    modeT        mode;
    logic [31:0] dataD;
    logic        unusedSeedBit;

    assign unusedSeedBit = seedValue[23];
    assign effSeed       = (seedValue[22:0] == 23'd0) ? Gen3DefaultSeed : seedValue[22:0];
    assign gen3Cur       = gen3Unseeded ? effSeed : gen3Q;

    always_comb begin
        case (PIPEWIDTH)
            6'd16:   activeMask = 4'b0011;
            6'd32:   activeMask = 4'b1111;
            default: activeMask = 4'b0001;
        endcase
    end

    always_comb begin
        case (PIPESyncHeader)
            2'b00:   mode = Mode8b10b;
            2'b10:   mode = ModeDataBlock;
            default: mode = ModeOrderedSet;
        endcase
    end

    // Bytes are walked in arrival order so each one sees the LFSR state the
    // previous byte left, including a COM reseed earlier in the same word.
    always_comb begin : descramble
        gen12StepT  step12;
        gen3StepT   step3;
        logic [7:0] byteVal;
        logic       isK;
        // NOTE: every variable this block writes is defaulted first, so no path can leave one unassigned and infer a latch.
        step12  = '0;
        step3   = '0;
        byteVal = '0;
        isK     = 1'b0;
        gen12D  = gen12Q;
        gen3D   = gen3Cur;
        dataD   = PIPEData;
        if (turnOff) begin
            gen12D = Gen12Seed;
            gen3D  = effSeed;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (activeMask[b]) begin
                    byteVal = PIPEData[8*b +: 8];
                    isK     = PIPEDataK[b];
                    case (mode)
                        Mode8b10b: begin
                            if (isK && byteVal == ComSymbol) begin
                                gen12D = Gen12Seed;
                            end else if (!(isK && byteVal == SkpSymbol)) begin
                                step12 = gen12Advance(gen12D);
                                gen12D = step12.state;
                                if (!isK) begin
                                    dataD[8*b +: 8] = byteVal ^ step12.key;
                                end
                            end
                        end
                        ModeDataBlock: begin
                            step3           = gen3Advance(gen3D);
                            gen3D           = step3.state;
                            dataD[8*b +: 8] = byteVal ^ step3.key;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: reset loads constants only; the input-dependent Gen3 seed is applied through gen3Unseeded instead of an asynchronous load.
            descramblerDataValid  <= 1'b0;
            descramblerData       <= '0;
            descramblerDataK      <= '0;
            descramblerSyncHeader <= '0;
            gen12Q                <= Gen12Seed;
            gen3Q                 <= '0;
            gen3Unseeded          <= 1'b1;
        end else begin
            // NOTE: non-blocking here for registered state; the combinational walk above uses blocking so bytes chain within one cycle.
            descramblerDataValid <= PIPEDataValid;
            if (PIPEDataValid) begin
                descramblerData       <= dataD;
                descramblerDataK      <= PIPEDataK;
                descramblerSyncHeader <= PIPESyncHeader;
                gen12Q                <= gen12D;
                gen3Q                 <= gen3D;
                gen3Unseeded          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_descrambler.sv
// Self-checking bench for descrambler: directed steps plus a randomized run,
// compared against keystream tables indexed by bytes consumed since the last reseed.
module tb_descrambler;

    logic        clk = 1'b0;
    logic        reset;
    logic        turnOff;
    logic        PIPEDataValid;
    logic [5:0]  PIPEWIDTH;
    logic [1:0]  PIPESyncHeader;
    logic [23:0] seedValue;
    logic [31:0] PIPEData;
    logic [3:0]  PIPEDataK;
    logic        descramblerDataValid;
    logic [31:0] descramblerData;
    logic [3:0]  descramblerDataK;
    logic [1:0]  descramblerSyncHeader;

    always #5 clk = ~clk;

    descrambler dut (
        .clk                  (clk),
        .reset                (reset),
        .turnOff              (turnOff),
        .PIPEDataValid        (PIPEDataValid),
        .PIPEWIDTH            (PIPEWIDTH),
        .PIPESyncHeader       (PIPESyncHeader),
        .seedValue            (seedValue),
        .PIPEData             (PIPEData),
        .PIPEDataK            (PIPEDataK),
        .descramblerDataValid (descramblerDataValid),
        .descramblerData      (descramblerData),
        .descramblerDataK     (descramblerDataK),
        .descramblerSyncHeader(descramblerSyncHeader)
    );

    localparam int KsLen = 4096;

    int         nCompared = 0;
    int         nMismatched = 0;
    logic [7:0] ks12 [KsLen];
    logic [7:0] ks3  [KsLen];
    int         i12;
    int         i3;
    logic        expValid;
    logic [31:0] expData;
    logic [3:0]  expK;
    logic [1:0]  expSync;

    // Keystreams as byte sequences from the seed; an LFSR state is "seed advanced j bytes".
    task automatic buildStreams(input logic [22:0] seed3);
        int s12;
        int s3;
        int o;
        s12 = 'hFFFF;
        s3  = int'(seed3);
        for (int j = 0; j < KsLen; j++) begin
            ks12[j] = 8'h00;
            ks3[j]  = 8'h00;
            for (int i = 0; i < 8; i++) begin
                o          = (s12 >> 15) & 1;
                ks12[j][i] = o[0];
                s12        = ((s12 << 1) & 'hFFFF) ^ ((o != 0) ? 'h39 : 0);
                o          = (s3 >> 22) & 1;
                ks3[j][i]  = o[0];
                s3         = ((s3 << 1) & 'h7FFFFF) ^ ((o != 0) ? 'h210125 : 0);
            end
        end
    endtask

    function automatic logic [22:0] effSeedOf(input logic [23:0] sv);
        return (sv[22:0] == 23'd0) ? 23'h1DBFBC : sv[22:0];
    endfunction

    task automatic modelReset();
        i12      = 0;
        i3       = 0;
        expValid = 1'b0;
        expData  = '0;
        expK     = '0;
        expSync  = '0;
    endtask

    task automatic modelWord(input logic v, input logic [5:0] w, input logic [1:0] sh,
                             input logic toff, input logic [31:0] d, input logic [3:0] k);
        int         n;
        logic [7:0] bv;
        expValid = v;
        if (!v) return;
        expK    = k;
        expSync = sh;
        expData = d;
        if (toff) begin
            i12 = 0;
            i3  = 0;
            return;
        end
        n = (w == 6'd16) ? 2 : (w == 6'd32) ? 4 : 1;
        for (int b = 0; b < n; b++) begin
            bv = d[8*b +: 8];
            if (sh == 2'b00) begin
                if (k[b] && bv == 8'hBC) i12 = 0;
                else if (k[b] && bv == 8'h1C) ;
                else begin
                    if (!k[b]) expData[8*b +: 8] = bv ^ ks12[i12];
                    i12++;
                end
            end else if (sh == 2'b10) begin
                expData[8*b +: 8] = bv ^ ks3[i3];
                i3++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        check($sformatf("%s.valid", tag), {31'd0, descramblerDataValid}, {31'd0, expValid});
        check($sformatf("%s.data", tag), descramblerData, expData);
        check($sformatf("%s.k", tag), {28'd0, descramblerDataK}, {28'd0, expK});
        check($sformatf("%s.sync", tag), {30'd0, descramblerSyncHeader}, {30'd0, expSync});
    endtask

    task automatic drive(input string tag, input logic v, input logic [5:0] w, input logic [1:0] sh,
                         input logic toff, input logic [31:0] d, input logic [3:0] k);
        @(negedge clk);
        PIPEDataValid  = v;
        PIPEWIDTH      = w;
        PIPESyncHeader = sh;
        turnOff        = toff;
        PIPEData       = d;
        PIPEDataK      = k;
        modelWord(v, w, sh, toff, d, k);
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    initial begin
        logic [5:0]  rw;
        logic [31:0] rd;
        logic [3:0]  rk;
        int          r;

        reset = 1'b0; turnOff = 1'b0; PIPEDataValid = 1'b0; PIPEWIDTH = 6'd32;
        PIPESyncHeader = 2'b00; seedValue = 24'd0; PIPEData = '0; PIPEDataK = '0;
        buildStreams(effSeedOf(seedValue));
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset");
        check("reset.dataZero", descramblerData, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Gen1: COM then data in one word, then SKP continuing the same sequence.
        drive("gen1.com32", 1'b1, 6'd32, 2'b00, 1'b0, 32'h0000_00BC, 4'b0001);
        check("gen1.com32.const", descramblerData, 32'hC017_FFBC);
        drive("gen1.skp", 1'b1, 6'd32, 2'b00, 1'b0, 32'h0000_1C00, 4'b0010);
        check("gen1.skp.byte0", {24'd0, descramblerData[7:0]}, 32'h14);
        check("gen1.skp.byte1", {24'd0, descramblerData[15:8]}, 32'h1C);

        // Bypass, then COM reseed at width 16.
        drive("bypass", 1'b1, 6'd32, 2'b00, 1'b1, 32'hAAAA_2525, 4'b0000);
        check("bypass.const", descramblerData, 32'hAAAA_2525);
        drive("afterBypass", 1'b1, 6'd16, 2'b00, 1'b0, 32'h1234_00BC, 4'b0001);
        check("afterBypass.const", descramblerData, 32'h1234_FFBC);

        // Width 8: only byte 0 active; upper bytes echoed even when flagged K.
        drive("w8.com", 1'b1, 6'd8, 2'b00, 1'b0, 32'hDEAD_BEBC, 4'b0001);
        check("w8.com.const", descramblerData, 32'hDEAD_BEBC);
        drive("w8.d0", 1'b1, 6'd8, 2'b00, 1'b0, 32'h1357_9B00, 4'b1110);
        check("w8.d0.const", descramblerData, 32'h1357_9BFF);
        drive("w8.d1", 1'b1, 6'd8, 2'b00, 1'b0, 32'hBCBC_BC00, 4'b1110);
        check("w8.d1.const", descramblerData, 32'hBCBC_BC17);
        drive("w8.d2", 1'b1, 6'd8, 2'b00, 1'b0, 32'h2468_AC00, 4'b0000);
        check("w8.d2.const", descramblerData, 32'h2468_ACC0);
        drive("w24asW8", 1'b1, 6'd24, 2'b00, 1'b0, 32'hA5A5_A500, 4'b0000);
        check("w24asW8.const", descramblerData, 32'hA5A5_A514);

        // 128b/130b: ordered sets pass, data blocks expose the Gen3 keystream.
        drive("os01", 1'b1, 6'd32, 2'b01, 1'b0, 32'hF0E1_D2C3, 4'b0101);
        check("os01.const", descramblerData, 32'hF0E1_D2C3);
        drive("g3.d0", 1'b1, 6'd32, 2'b10, 1'b0, 32'h0, 4'b0000);
        drive("g3.idle0", 1'b0, 6'd32, 2'b10, 1'b0, 32'hFFFF_FFFF, 4'b1111);
        drive("g3.idle1", 1'b0, 6'd32, 2'b00, 1'b0, 32'h1234_5678, 4'b0000);
        drive("g3.d1", 1'b1, 6'd32, 2'b10, 1'b0, 32'h0, 4'b1001);
        drive("os11", 1'b1, 6'd32, 2'b11, 1'b0, 32'h0BAD_CAFE, 4'b0000);
        check("os11.const", descramblerData, 32'h0BAD_CAFE);
        drive("g3.d2", 1'b1, 6'd16, 2'b10, 1'b0, 32'h5A5A_0000, 4'b0000);
        drive("g3.d3", 1'b1, 6'd32, 2'b10, 1'b0, 32'h0, 4'b0000);

        // Asynchronous reset mid-stream discards the in-flight word.
        @(negedge clk);
        PIPEDataValid = 1'b1; PIPEWIDTH = 6'd32; PIPESyncHeader = 2'b10;
        PIPEData = 32'hCAFE_F00D; PIPEDataK = 4'b0000;
        #2 reset = 1'b0;
        modelReset();
        #1;
        checkAll("midReset.async");
        @(posedge clk);
        #1;
        checkAll("midReset.held");
        @(negedge clk);
        PIPEDataValid = 1'b0;
        reset = 1'b1;
        drive("postReset.gen1", 1'b1, 6'd8, 2'b00, 1'b0, 32'h0, 4'b0000);
        check("postReset.gen1.const", descramblerData, 32'h0000_00FF);
        drive("postReset.gen3", 1'b1, 6'd32, 2'b10, 1'b0, 32'h0, 4'b0000);

        // Randomized mix of modes, widths, control symbols, bypass and idles.
        for (int c = 0; c < 400; c++) begin
            r  = $urandom_range(0, 3);
            rw = (r == 0) ? 6'd8 : (r == 1) ? 6'd16 : (r == 2) ? 6'd32 : 6'($urandom_range(0, 63));
            rd = $urandom;
            rk = 4'b0000;
            for (int b = 0; b < 4; b++) begin
                r = $urandom_range(0, 7);
                if (r == 0) begin rd[8*b +: 8] = 8'hBC; rk[b] = 1'b1; end
                else if (r == 1) begin rd[8*b +: 8] = 8'h1C; rk[b] = 1'b1; end
                else if (r == 2) rk[b] = 1'b1;
            end
            drive($sformatf("rand%0d", c), $urandom_range(0, 7) != 0, rw,
                  2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0, rd, rk);
        end

        // Custom Gen3 seed; bit 23 of seedValue is ignored.
        @(negedge clk);
        PIPEDataValid = 1'b0;
        seedValue = 24'h8A_BCDE;
        reset = 1'b0;
        buildStreams(effSeedOf(seedValue));
        modelReset();
        @(posedge clk);
        #1;
        checkAll("seedReset");
        @(negedge clk);
        reset = 1'b1;
        drive("seed.d0", 1'b1, 6'd32, 2'b10, 1'b0, 32'h0, 4'b0000);
        drive("seed.idle", 1'b0, 6'd32, 2'b10, 1'b0, 32'h0, 4'b0000);
        drive("seed.d1", 1'b1, 6'd32, 2'b10, 1'b0, 32'h0, 4'b0000);
        drive("seed.bypass", 1'b1, 6'd32, 2'b10, 1'b1, 32'h7777_0000, 4'b0000);
        drive("seed.d2", 1'b1, 6'd32, 2'b10, 1'b0, 32'h0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/descrambler.md
# descrambler

Per-lane receive descrambler between the PIPE receive-data stage and the lane-merge (LMC) stage of the PCIe physical-layer RX path; one instance per lane (16 in the RX top). It removes 8b/10b-era (Gen1/2) and 128b/130b (Gen3+) scrambling from up to 4 bytes per clock. Control symbols, and ordered-set blocks in 128b/130b mode, pass through untouched. Output is registered with one cycle of latency and can be bypassed by the LTSSM during training.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- turnOff  input  1  bypass: data passes unmodified, both LFSRs held at seed.
- PIPEDataValid  input  1  input word valid.
- PIPEWIDTH  input  6  active bits per word: 8, 16 or 32; any other value is treated as 8.
- PIPESyncHeader  input  2  2'b00 = 8b/10b mode, 2'b10 = 128b/130b data block, 2'b01 = 128b/130b ordered-set block, 2'b11 = treated as 2'b01.
- seedValue  input  24  Gen3 LFSR seed (bits 22:0 used); 0 selects default 23'h1DBFBC.
- PIPEData  input  32  received bytes, byte 0 = bits 7:0, earliest in time.
- PIPEDataK  input  4  per-byte K (control) flag.
- descramblerDataValid  output  1  registered PIPEDataValid.
- descramblerData  output  32  descrambled bytes.
- descramblerDataK  output  4  registered PIPEDataK.
- descramblerSyncHeader  output  2  registered PIPESyncHeader.

## Operation
- Active byte count N = PIPEWIDTH/8 (1, 2 or 4). Bytes are processed in order 0..N-1, each seeing the LFSR state left by the previous byte. Bytes at index >= N pass unchanged and do not advance the LFSR.
- Gen1/2 LFSR (16 bits, x^16+x^5+x^4+x^3+1), Galois form, seed 16'hFFFF. One shift: out = L[15]; L = {L[14:0],1'b0} ^ (out ? 16'h0039 : 0). Scramble byte bit i = out of the i-th shift (i = 0 first).
- Gen3 LFSR (23 bits, x^23+x^21+x^16+x^8+x^5+x^2+1), same form: out = L[22], feedback mask 23'h210125, seed = effective seedValue.
- 8b/10b mode (sync header 2'b00), per byte:
  - K=1 and byte 8'hBC (COM): output unchanged; Gen1/2 LFSR set to 16'hFFFF, which the next byte uses.
  - K=1 and byte 8'h1C (SKP): output unchanged; LFSR not advanced.
  - Any other K=1 byte: output unchanged; LFSR advances 8 shifts.
  - K=0 byte: output = byte XOR scramble byte; LFSR advances 8 shifts.
- 128b/130b data block (2'b10): every active byte is XORed with the Gen3 scramble byte and advances the Gen3 LFSR 8 shifts. K flags are ignored for scrambling but still forwarded.
- 128b/130b ordered-set block (2'b01/2'b11): bytes pass unchanged; Gen3 LFSR holds.
- Each LFSR advances only in its own mode; the inactive LFSR holds.
- turnOff=1: every byte passes unchanged; both LFSRs load their seeds each valid cycle.
- PIPEDataValid=0: LFSRs hold; descramblerDataValid=0 next cycle; descramblerData, descramblerDataK and descramblerSyncHeader hold their last values.

## Timing
- Every output is a flop updated on the rising clk edge: input at edge k appears at outputs after edge k; latency is 1 cycle.
- No handshake and no backpressure; a new word is accepted every cycle.
- Reset (reset=0, asynchronous): all outputs go to 0; Gen1/2 LFSR = 16'hFFFF; Gen3 LFSR = effective seed. Reset asserted mid-stream discards the in-flight word.
- COM reseeding takes effect inside the same word, so a data byte following COM in the same cycle uses the 16'hFFFF state.
- A change of turnOff or sync header takes effect for the word presented in that cycle.

## Test plan
- Reset: hold reset=0 -> all outputs 0. Release, then present a COM followed by data in 8b/10b mode -> the first data byte after COM is descrambled with the 16'hFFFF state.
- Gen1, PIPEWIDTH=32, PIPEData=32'h0000_00BC, PIPEDataK=4'b0001 -> next cycle descramblerData=32'hC0_17_FF_BC, K=4'b0001, valid=1.
- Same word, then a second word 32'h00001C00 with K=4'b0010 -> SKP passes as 8'h1C without advancing the LFSR, so byte 0 decodes as 8'h14 (sequence FF,17,C0,14).
- turnOff=1 with any data, e.g. 32'hAAAA2525 -> output identical to input one cycle later; after turnOff drops, the first data byte following a COM decodes against 16'hFFFF.
- PIPEWIDTH=8: COM then 3 data bytes, one per cycle -> decoded with FF, 17, C0; upper input bytes are echoed unchanged.
- 128b/130b: sync header 2'b01 word passes unchanged; then 2'b10 words with data 0 -> output equals the Gen3 keystream seeded with 23'h1DBFBC; PIPEDataValid=0 cycles in between do not change the keystream.
